// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one external memory port between the instruction-fetch requester
// (icache refill) and the data load/store requester. One transaction is in
// flight at a time. Data has fixed priority over instruction fetch, but a
// starvation counter hands the port to a waiting instruction request after
// STARVE_MAX consecutive data grants.
//
// Address, write data and direction are latched at grant and held until the
// memory acknowledges. Read data and a one-cycle completion pulse go back to
// the owning requester.
//
// Optional feature macro: MEMARB_TIMEOUT_EN
//   Defined   : a 16-bit wait counter aborts a bus cycle after TIMEOUT cycles
//               without ack; the owner gets zero read data, its valid pulse
//               and o_bus_err in the same cycle.
//   Undefined : the arbiter waits indefinitely for ack; o_bus_err is tied 0.
//
// Parameters:
//   STARVE_MAX  consecutive data grants allowed while an instruction waits (1..15)
//   TIMEOUT     bus-wait cycle limit, only with MEMARB_TIMEOUT_EN (1..65535)
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   i_ireq, i_iaddr          instruction read request (level) and address
//   o_irdata, o_ivalid       instruction read data and completion pulse
//   i_drd, i_dwr             data read / write requests (level)
//   i_daddr, i_dwdata        data address and write data
//   o_drdata, o_dvalid       data read data and completion pulse
//   o_mem_req/we/addr/wdata  memory request side, held until i_mem_ack
//   i_mem_rdata, i_mem_ack   memory response side
//   o_busy                   arbiter not idle (decoded from state)
//   o_owner                  0 none, 1 instruction, 2 data
//   o_bus_err                timeout pulse, coincident with the valid pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_MAX = 4
`ifdef MEMARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ireq,
  input  logic [31:0] i_iaddr,
  output logic [31:0] o_irdata,
  output logic        o_ivalid,
  input  logic        i_drd,
  input  logic        i_dwr,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dwdata,
  output logic [31:0] o_drdata,
  output logic        o_dvalid,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic [1:0]  o_owner,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_INSTR  = 2'd1;
  localparam logic [1:0] OWN_DATA   = 2'd2;

  state_t      r_state;
  logic [3:0]  r_starve;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_irdata;
  logic [31:0] r_drdata;
  logic        r_ivalid;
  logic        r_dvalid;
  logic [1:0]  r_owner;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  logic [15:0] r_wait;
  logic        r_bus_err;
`endif

  logic       w_dpend;
  logic       w_starved;
  logic       w_gnt_d;
  logic       w_gnt_i;
  logic [3:0] w_starve_inc;

  // Grant decision for the IDLE state: data wins unless an instruction
  // request has already been passed over STARVE_MAX times in a row.
  assign w_dpend   = i_drd | i_dwr;
  assign w_starved = (r_starve == STARVE_LIM);
  assign w_gnt_d   = w_dpend & ~(i_ireq & w_starved);
  assign w_gnt_i   = i_ireq & ~w_gnt_d;

  // Saturating increment keeps the counter pinned at the limit.
  assign w_starve_inc = w_starved ? r_starve : (r_starve + 4'd1);

  // Arbiter FSM: grant, bus wait, completion pulse, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_starve    <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_irdata    <= 32'h0;
      r_drdata    <= 32'h0;
      r_ivalid    <= 1'b0;
      r_dvalid    <= 1'b0;
      r_owner     <= OWN_NONE;
`ifdef MEMARB_TIMEOUT_EN
      r_wait      <= 16'd0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ivalid <= 1'b0;
          r_dvalid <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
          r_bus_err <= 1'b0;
          r_wait    <= 16'd0;
`endif
          if (w_gnt_d) begin
            r_state     <= ST_DBUS;
            r_owner     <= OWN_DATA;
            r_mem_req   <= 1'b1;
            // A simultaneous read and write request is served as a write.
            r_mem_we    <= i_dwr;
            r_mem_addr  <= i_daddr;
            r_mem_wdata <= i_dwdata;
            // Only count grants that actually passed over a waiting fetch.
            r_starve    <= i_ireq ? w_starve_inc : 4'd0;
          end else if (w_gnt_i) begin
            r_state     <= ST_IBUS;
            r_owner     <= OWN_INSTR;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_iaddr;
            r_mem_wdata <= 32'h0;
            r_starve    <= 4'd0;
          end else begin
            // Nothing pending, so no instruction request is waiting either.
            r_owner  <= OWN_NONE;
            r_starve <= 4'd0;
          end
        end

        ST_IBUS, ST_DBUS: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (r_state == ST_IBUS) begin
              r_irdata <= i_mem_rdata;
              r_ivalid <= 1'b1;
            end else begin
              // Write completions leave the last read data untouched.
              if (!r_mem_we) begin
                r_drdata <= i_mem_rdata;
              end
              r_dvalid <= 1'b1;
            end
          end
`ifdef MEMARB_TIMEOUT_EN
          else if (r_wait == TIMEOUT_M1) begin
            // Abort: an ack in this same cycle would have taken the branch above.
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            r_bus_err <= 1'b1;
            if (r_state == ST_IBUS) begin
              r_irdata <= 32'h0;
              r_ivalid <= 1'b1;
            end else begin
              r_drdata <= 32'h0;
              r_dvalid <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + 16'd1;
          end
`endif
        end

        ST_DONE: begin
          // Requests are ignored here so a still-held request is not re-granted.
          r_ivalid <= 1'b0;
          r_dvalid <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
          r_bus_err <= 1'b0;
`endif
          r_owner  <= OWN_NONE;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_owner   <= OWN_NONE;
          r_mem_req <= 1'b0;
          r_ivalid  <= 1'b0;
          r_dvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign o_irdata    = r_irdata;
  assign o_ivalid    = r_ivalid;
  assign o_drdata    = r_drdata;
  assign o_dvalid    = r_dvalid;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_owner     = r_owner;
  assign o_busy      = (r_state != ST_IDLE);

`ifdef MEMARB_TIMEOUT_EN
  assign o_bus_err = r_bus_err;
`else
  assign o_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-level reference model
// predicts which requester wins each grant (data priority with a bounded
// starvation count), what address/direction the memory port must show, and
// what read data each requester must end up holding.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ireq;
  logic [31:0] i_iaddr;
  logic [31:0] o_irdata;
  logic        o_ivalid;
  logic        i_drd;
  logic        i_dwr;
  logic [31:0] i_daddr;
  logic [31:0] i_dwdata;
  logic [31:0] o_drdata;
  logic        o_dvalid;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_busy;
  logic [1:0]  o_owner;
  logic        o_bus_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          m_starve;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX)
`ifdef MEMARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_irdata(o_irdata), .o_ivalid(o_ivalid),
    .i_drd(i_drd), .i_dwr(i_dwr), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
    .o_drdata(o_drdata), .o_dvalid(o_dvalid),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_busy(o_busy), .o_owner(o_owner), .o_bus_err(o_bus_err)
  );

  // One full transaction starting from an IDLE negedge with requests already
  // driven. Requests stay held through DONE so a re-grant would be visible.
  task automatic do_txn(input int ack_delay, input bit scramble, input bit withdraw,
                        input logic [31:0] rdata, output logic [1:0] exp_owner);
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    if ((i_drd || i_dwr) && !(i_ireq && m_starve == STARVE_MAX)) begin
      exp_owner = 2'd2;
      e_addr    = i_daddr;
      e_wdata   = i_dwdata;
      e_we      = i_dwr;
      if (i_ireq) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else        m_starve = 0;
    end else begin
      exp_owner = 2'd1;
      e_addr    = i_iaddr;
      e_wdata   = 32'h0;
      e_we      = 1'b0;
      m_starve  = 0;
    end

    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_mem_req !== 1'b1 || o_owner !== exp_owner || o_busy !== 1'b1 ||
        o_ivalid !== 1'b0 || o_dvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL grant: req=%b owner=%0d busy=%b iv=%b dv=%b, expected req=1 owner=%0d busy=1 iv=0 dv=0",
               o_mem_req, o_owner, o_busy, o_ivalid, o_dvalid, exp_owner);
    end
    vectors++;
    if (o_mem_addr !== e_addr || o_mem_we !== e_we) begin
      miscompares++;
      $display("FAIL grant_addr: addr=%h we=%b, expected addr=%h we=%b", o_mem_addr, o_mem_we, e_addr, e_we);
    end
    if (exp_owner == 2'd2) begin
      vectors++;
      if (o_mem_wdata !== e_wdata) begin
        miscompares++;
        $display("FAIL grant_wdata: wdata=%h, expected %h", o_mem_wdata, e_wdata);
      end
    end

    for (int k = 0; k < ack_delay; k++) begin
      if (scramble) begin
        i_daddr  = $urandom;
        i_dwdata = $urandom;
        i_iaddr  = $urandom;
      end
      if (withdraw) begin
        if (exp_owner == 2'd2) {i_drd, i_dwr} = 2'b00;
        else                   i_ireq = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      vectors++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== e_addr || o_mem_we !== e_we ||
          o_ivalid !== 1'b0 || o_dvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_hold: req=%b addr=%h we=%b iv=%b dv=%b, expected req=1 addr=%h we=%b iv=0 dv=0",
                 o_mem_req, o_mem_addr, o_mem_we, o_ivalid, o_dvalid, e_addr, e_we);
      end
    end

    i_mem_ack   = 1'b1;
    i_mem_rdata = rdata;
    @(posedge clk); @(negedge clk);
    i_mem_ack   = 1'b0;
    i_mem_rdata = $urandom;
    if (exp_owner == 2'd1) m_irdata = rdata;
    else if (!e_we)        m_drdata = rdata;

    vectors++;
    if (o_ivalid !== (exp_owner == 2'd1) || o_dvalid !== (exp_owner == 2'd2) ||
        o_owner !== exp_owner || o_mem_req !== 1'b0 || o_busy !== 1'b1 || o_bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL done: iv=%b dv=%b owner=%0d req=%b busy=%b err=%b, expected owner=%0d req=0 busy=1 err=0",
               o_ivalid, o_dvalid, o_owner, o_mem_req, o_busy, o_bus_err, exp_owner);
    end
    vectors++;
    if (o_irdata !== m_irdata || o_drdata !== m_drdata) begin
      miscompares++;
      $display("FAIL rdata: irdata=%h drdata=%h, expected irdata=%h drdata=%h",
               o_irdata, o_drdata, m_irdata, m_drdata);
    end

    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || o_owner !== 2'd0 || o_mem_req !== 1'b0 ||
        o_ivalid !== 1'b0 || o_dvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL back_idle: busy=%b owner=%0d req=%b iv=%b dv=%b, expected all 0",
               o_busy, o_owner, o_mem_req, o_ivalid, o_dvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_ireq = 1'b1; i_drd = 1'b1; i_dwr = 1'b0;
    i_iaddr = 32'h1111_0000; i_daddr = 32'h2222_0000; i_dwdata = 32'h3333_0000;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_owner !== 2'd0 ||
        o_ivalid !== 1'b0 || o_dvalid !== 1'b0 || o_bus_err !== 1'b0 || o_mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req=%b busy=%b owner=%0d iv=%b dv=%b err=%b we=%b, expected all 0",
               o_mem_req, o_busy, o_owner, o_ivalid, o_dvalid, o_bus_err, o_mem_we);
    end
    vectors++;
    if (o_irdata !== 32'h0 || o_drdata !== 32'h0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: irdata=%h drdata=%h addr=%h wdata=%h, expected all 0",
               o_irdata, o_drdata, o_mem_addr, o_mem_wdata);
    end
    i_ireq = 1'b0; i_drd = 1'b0; i_mem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b req=%b, expected 0 0", o_busy, o_mem_req);
    end
    m_starve = 0; m_irdata = 32'h0; m_drdata = 32'h0;
  endtask

  task automatic test_single_iread();
    logic [1:0] own;
    i_ireq = 1'b1; i_iaddr = 32'h0000_0100;
    do_txn(0, 1'b0, 1'b0, 32'h0050_0093, own);
    vectors++;
    if (o_irdata !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL iread_data: irdata=%h, expected 00500093", o_irdata);
    end
    i_ireq = 1'b0;
  endtask

  task automatic test_starvation();
    logic [1:0] own;
    logic [1:0] seq [10];
    seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    i_ireq = 1'b1; i_iaddr = 32'h0000_4000;
    for (int t = 0; t < 10; t++) begin
      i_drd = 1'b1; i_daddr = $urandom;
      do_txn($urandom_range(0, 2), 1'b0, 1'b0, $urandom, own);
      // Hard-coded ownership sequence, independent of the model counter.
      vectors++;
      if (own !== seq[t]) begin
        miscompares++;
        $display("FAIL starve_seq[%0d]: model owner=%0d, expected %0d", t, own, seq[t]);
      end
      i_ireq = 1'b1; i_iaddr = $urandom;
    end
    i_ireq = 1'b0; i_drd = 1'b0;
  endtask

  task automatic test_write_wait();
    logic [1:0]  own;
    logic [31:0] prev_drdata;
    prev_drdata = m_drdata;
    i_dwr = 1'b1; i_daddr = 32'h0000_2000; i_dwdata = 32'hDEAD_BEEF;
    do_txn(5, 1'b1, 1'b0, 32'h1234_5678, own);
    vectors++;
    if (o_drdata !== prev_drdata) begin
      miscompares++;
      $display("FAIL write_drdata: drdata=%h, expected unchanged %h", o_drdata, prev_drdata);
    end
    i_dwr = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_drd = 1'b1; i_daddr = 32'h0000_8000;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_mem_req !== 1'b1 || o_owner !== 2'd2) begin
      miscompares++;
      $display("FAIL rstmid_grant: req=%b owner=%0d, expected 1 2", o_mem_req, o_owner);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_owner !== 2'd0) begin
      miscompares++;
      $display("FAIL rstmid_drop: req=%b busy=%b owner=%0d, expected 0 0 0", o_mem_req, o_busy, o_owner);
    end
    rst = 1'b1; i_drd = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    i_mem_ack = 1'b0;
    vectors++;
    if (o_dvalid !== 1'b0 || o_busy !== 1'b0 || o_drdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_late_ack: dvalid=%b busy=%b drdata=%h, expected 0 0 0", o_dvalid, o_busy, o_drdata);
    end
    m_starve = 0; m_irdata = 32'h0; m_drdata = 32'h0;
  endtask

`ifdef MEMARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] own;
    i_drd = 1'b1; i_daddr = 32'h0000_C000;
    m_starve = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); @(negedge clk);
      if (k < 8) begin
        vectors++;
        if (o_mem_req !== 1'b1 || o_dvalid !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_wait[%0d]: req=%b dvalid=%b, expected 1 0", k, o_mem_req, o_dvalid);
        end
      end
    end
    vectors++;
    if (o_mem_req !== 1'b0 || o_dvalid !== 1'b1 || o_bus_err !== 1'b1 || o_drdata !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_abort: req=%b dvalid=%b err=%b drdata=%h, expected 0 1 1 0",
               o_mem_req, o_dvalid, o_bus_err, o_drdata);
    end
    m_drdata = 32'h0;
    i_drd = 1'b0;
    @(posedge clk); @(negedge clk);
    i_drd = 1'b1; i_daddr = $urandom;
    do_txn(2, 1'b0, 1'b0, $urandom, own);
    i_drd = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [1:0] own;
    for (int n = 0; n < 150; n++) begin
      if (!i_ireq && $urandom_range(0, 1) == 1) begin
        i_ireq = 1'b1; i_iaddr = $urandom;
      end else if (i_ireq && $urandom_range(0, 7) == 0) begin
        i_ireq = 1'b0;
      end
      if (!(i_drd || i_dwr) && $urandom_range(0, 1) == 1) begin
        {i_drd, i_dwr} = 2'($urandom_range(1, 3));
        i_daddr = $urandom; i_dwdata = $urandom;
      end
      if (!(i_ireq || i_drd || i_dwr)) begin
        m_starve = 0;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_idle: busy=%b req=%b, expected 0 0", o_busy, o_mem_req);
        end
      end else begin
        do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
               $urandom, own);
        if (own == 2'd1) i_ireq = 1'b0;
        else             {i_drd, i_dwr} = 2'b00;
      end
    end
    i_ireq = 1'b0; i_drd = 1'b0; i_dwr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_iread();
    test_starvation();
    test_write_wait();
    test_reset_mid();
`ifdef MEMARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
